terminal_arbiter: RTL and testbench

Shares the single write port of the 80x30 text terminal character buffer (addresses 0..2399) between two requesters: the debugger state dump (req0) and a CPU console/print stream (req1).
Round-robin arbitration uses valid/ready handshakes. A built-in clear sequencer blanks the whole screen on command.
Sits between the requesters and the terminal buffer write port, replacing the direct always-write connection.

---
 rtl/terminal_pkg.sv | 38 +++
 rtl/terminal_arbiter_if.sv | 34 +++
 rtl/terminal_arbiter_rr_arbiter2.sv | 48 ++++
 rtl/terminal_arbiter.sv | 166 ++++++++++++++++
 tb/tb_terminal_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/terminal_pkg.sv
// -----------------------------------------------------------------------------
// terminal_pkg
// Constants and helpers for the 80x30 text terminal character buffer.
// Other files import this package for:
//   - the geometry and address range of the screen
//   - the state encoding of the write-port arbiter
//   - calc_terminal_addr(row, column), which the debugger also uses to build
//     linear buffer addresses
// -----------------------------------------------------------------------------
package terminal_pkg;

   localparam int TERMINAL_COLUMN_MAX = 80;
   localparam int TERMINAL_ROW_MAX    = 30;
   localparam int TERMINAL_ADDR_W     = 12;
   localparam int TERMINAL_DATA_W     = 8;

   // Last valid linear address: 80 * 30 - 1 = 2399.
   localparam logic [TERMINAL_ADDR_W-1:0] TERMINAL_ADDR_MAX =
      12'(TERMINAL_COLUMN_MAX * TERMINAL_ROW_MAX - 1);

   // ASCII space, used to blank the screen.
   localparam logic [TERMINAL_DATA_W-1:0] BLANK_CHAR = 8'h20;

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } arb_state_t;

   // Linear buffer address of a character cell; rows are stored back to back.
   function automatic logic [TERMINAL_ADDR_W-1:0] calc_terminal_addr(
      input logic [4:0] row,
      input logic [6:0] column
   );
      return TERMINAL_ADDR_W'(row) * TERMINAL_ADDR_W'(TERMINAL_COLUMN_MAX)
             + TERMINAL_ADDR_W'(column);
   endfunction

endpackage

// File: rtl/terminal_arbiter_if.sv
// -----------------------------------------------------------------------------
// terminal_arbiter_if
// Write-request channel into the terminal arbiter. Each requester owns one
// instance of this interface.
//   valid : requester has a character to write
//   ready : the write is accepted this cycle (combinational from the arbiter)
//   addr  : target linear buffer address
//   data  : character to write
// Modports:
//   master : the requester side
//   slave  : the arbiter side
// -----------------------------------------------------------------------------
interface terminal_arbiter_if;

   logic                                  valid;
   logic                                  ready;
   logic [terminal_pkg::TERMINAL_ADDR_W-1:0] addr;
   logic [terminal_pkg::TERMINAL_DATA_W-1:0] data;

   modport master (
      output valid,
      output addr,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  addr,
      input  data,
      output ready
   );

endinterface

// File: rtl/terminal_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant.
//   clock  : system clock
//   reset  : synchronous, active-high; makes requester 0 win the first tie
//   req    : request vector; bit N set when requester N may be granted
//   update : a transfer happened this cycle, so remember the current grant
//   grant  : one-hot (or zero) combinational grant
// -----------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   // Set when requester 1 received the most recent grant.
   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // On a tie, favour whoever was not served last.
         2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (update) begin
         last_grant_d = grant[1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/terminal_arbiter.sv
// -----------------------------------------------------------------------------
// terminal_arbiter
// Shares the single terminal buffer write port between two requesters:
//   req0 : debugger state dump
//   req1 : CPU console stream
// Requesters are served round robin. A clear sequencer can also blank the
// whole screen with BLANK_CHAR.
// Ports:
//   clock          : system clock
//   reset          : synchronous, active-high
//   clear_start    : one-cycle pulse that starts a full-screen clear
//   clear_busy     : registered; high while the clear sequence is writing
//   req0, req1     : request channels (slave side)
//   terminal_addr  : registered buffer write address
//   terminal_write : registered buffer write enable
//   terminal_data  : registered buffer write character
//   addr_error     : sticky; an accepted request had addr > ADDR_MAX
// -----------------------------------------------------------------------------
module terminal_arbiter #(
   parameter logic [terminal_pkg::TERMINAL_ADDR_W-1:0] ADDR_MAX   = terminal_pkg::TERMINAL_ADDR_MAX,
   parameter logic [terminal_pkg::TERMINAL_DATA_W-1:0] BLANK_CHAR = terminal_pkg::BLANK_CHAR
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clear_start,
   output logic                     clear_busy,
   terminal_arbiter_if.slave        req0,
   terminal_arbiter_if.slave        req1,
   output logic [11:0]              terminal_addr,
   output logic                     terminal_write,
   output logic [7:0]               terminal_data,
   output logic                     addr_error
);

   import terminal_pkg::*;

   arb_state_t state_q;
   arb_state_t state_d;

   logic [TERMINAL_ADDR_W-1:0] cnt_q;
   logic [TERMINAL_ADDR_W-1:0] cnt_d;
   logic [TERMINAL_ADDR_W-1:0] taddr_q;
   logic [TERMINAL_ADDR_W-1:0] taddr_d;
   logic [TERMINAL_DATA_W-1:0] tdata_q;
   logic [TERMINAL_DATA_W-1:0] tdata_d;
   logic                       write_q;
   logic                       write_d;
   logic                       busy_q;
   logic                       busy_d;
   logic                       err_q;
   logic                       err_d;

   logic                       arb_open;
   logic [1:0]                 req_vec;
   logic [1:0]                 grant;
   logic [TERMINAL_ADDR_W-1:0] sel_addr;
   logic [TERMINAL_DATA_W-1:0] sel_data;

   // Requests are only eligible in ARB and when no clear is being started;
   // clear_start takes priority over anything pending.
   assign arb_open = (state_q == ARB) && !clear_start;
   assign req_vec  = {req1.valid, req0.valid} & {2{arb_open}};

   // ready equals grant, so any grant is a transfer.
   rr_arbiter2 u_rr (
      .clock  (clock),
      .reset  (reset),
      .req    (req_vec),
      .update (|grant),
      .grant  (grant)
   );

   assign req0.ready = grant[0];
   assign req1.ready = grant[1];

   assign sel_addr = grant[1] ? req1.addr : req0.addr;
   assign sel_data = grant[1] ? req1.data : req0.data;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ARB;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; clear_start is ignored once a clear is running.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB: begin
            if (clear_start) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (cnt_q == ADDR_MAX) begin
               state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      cnt_d   = cnt_q;
      taddr_d = taddr_q;
      tdata_d = tdata_q;
      write_d = 1'b0;
      err_d   = err_q;
      busy_d  = (state_d == CLEAR);
      case (state_q)
         ARB: begin
            // Keeps the counter at 0, ready for the next clear.
            cnt_d = '0;
            if (|grant) begin
               // Out-of-range writes are accepted but dropped, so the
               // requester never stalls.
               if (sel_addr > ADDR_MAX) begin
                  err_d = 1'b1;
               end else begin
                  write_d = 1'b1;
                  taddr_d = sel_addr;
                  tdata_d = sel_data;
               end
            end
         end
         CLEAR: begin
            write_d = 1'b1;
            taddr_d = cnt_q;
            tdata_d = BLANK_CHAR;
            cnt_d   = (cnt_q == ADDR_MAX) ? '0 : cnt_q + 1'b1;
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         taddr_q <= '0;
         tdata_q <= '0;
         write_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         taddr_q <= taddr_d;
         tdata_q <= tdata_d;
         write_q <= write_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign terminal_addr  = taddr_q;
   assign terminal_data  = tdata_q;
   assign terminal_write = write_q;
   assign clear_busy     = busy_q;
   assign addr_error     = err_q;

endmodule

// File: tb/tb_terminal_arbiter.sv
module tb_terminal_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        clear_start;
   logic        clear_busy;
   logic [11:0] terminal_addr;
   logic        terminal_write;
   logic [7:0]  terminal_data;
   logic        addr_error;

   terminal_arbiter_if req0_if ();
   terminal_arbiter_if req1_if ();

   terminal_arbiter dut (
      .clock          (clock),
      .reset          (reset),
      .clear_start    (clear_start),
      .clear_busy     (clear_busy),
      .req0           (req0_if),
      .req1           (req1_if),
      .terminal_addr  (terminal_addr),
      .terminal_write (terminal_write),
      .terminal_data  (terminal_data),
      .addr_error     (addr_error)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        wr;
      logic [11:0] addr;
      logic [7:0]  data;
      logic        busy;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model state: what the screen port should look like after
   // each clock edge, derived from the arbitration and clear rules.
   bit          m_clearing;
   int          m_cnt;
   bit          m_last_was_1;
   bit          m_err;
   bit          m_wr;
   logic [11:0] m_addr;
   logic [7:0]  m_data;
   bit          g0, g1;

   // Requester stimulus
   bit          v0, v1;
   logic [11:0] a0, a1;
   logic [7:0]  d0, d1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic logic [11:0] rand_addr();
      if ($urandom_range(0, 15) == 0) return 12'($urandom_range(2400, 4095));
      return 12'($urandom_range(0, 2399));
   endfunction

   // One clock cycle: drive inputs, predict grants and next outputs.
   task automatic step(input bit rst_i, input bit cs_i);
      exp_t        e;
      logic [11:0] ga;
      logic [7:0]  gd;
      @(negedge clock);
      reset         = rst_i;
      clear_start   = cs_i;
      req0_if.valid = v0;
      req0_if.addr  = a0;
      req0_if.data  = d0;
      req1_if.valid = v1;
      req1_if.addr  = a1;
      req1_if.data  = d1;
      #1;
      g0 = 1'b0;
      g1 = 1'b0;
      if (rst_i) begin
         m_clearing   = 1'b0;
         m_cnt        = 0;
         m_last_was_1 = 1'b1;
         m_err        = 1'b0;
         m_wr         = 1'b0;
         m_addr       = '0;
         m_data       = '0;
      end else if (!m_clearing) begin
         if (!cs_i) begin
            if (v0 && v1) begin
               g0 = m_last_was_1;
               g1 = !m_last_was_1;
            end else begin
               g0 = v0;
               g1 = v1;
            end
         end
         chk("req0_ready", 32'(req0_if.ready), 32'(g0));
         chk("req1_ready", 32'(req1_if.ready), 32'(g1));
         m_wr = 1'b0;
         if (cs_i) begin
            m_clearing = 1'b1;
            m_cnt      = 0;
         end else if (g0 || g1) begin
            ga           = g1 ? a1 : a0;
            gd           = g1 ? d1 : d0;
            m_last_was_1 = g1;
            if (ga > 12'd2399) begin
               m_err = 1'b1;
            end else begin
               m_wr   = 1'b1;
               m_addr = ga;
               m_data = gd;
            end
         end
      end else begin
         chk("req0_ready_clr", 32'(req0_if.ready), 32'd0);
         chk("req1_ready_clr", 32'(req1_if.ready), 32'd0);
         m_wr   = 1'b1;
         m_addr = 12'(m_cnt);
         m_data = 8'h20;
         if (m_cnt == 2399) m_clearing = 1'b0;
         else m_cnt++;
      end
      e.wr   = m_wr;
      e.addr = m_addr;
      e.data = m_data;
      e.busy = m_clearing;
      e.err  = m_err;
      exp_q.push_back(e);
   endtask

   // Monitor: compares the registered outputs after each edge against the
   // oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("terminal_write", 32'(terminal_write), 32'(e.wr));
            chk("terminal_addr",  32'(terminal_addr),  32'(e.addr));
            chk("terminal_data",  32'(terminal_data),  32'(e.data));
            chk("clear_busy",     32'(clear_busy),     32'(e.busy));
            chk("addr_error",     32'(addr_error),     32'(e.err));
         end
      end
   end

   initial begin
      reset         = 1'b1;
      clear_start   = 1'b0;
      req0_if.valid = 1'b0;
      req0_if.addr  = '0;
      req0_if.data  = '0;
      req1_if.valid = 1'b0;
      req1_if.addr  = '0;
      req1_if.data  = '0;
      v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;

      step(1, 0);
      step(1, 0);

      // Single requester
      v0 = 1; a0 = 12'd8; d0 = 8'h41;
      step(0, 0);
      v0 = 0;
      step(0, 0);

      // Both valid from a fresh reset: req0 wins the first tie, then alternate
      step(1, 0);
      v0 = 1; v1 = 1;
      a0 = 12'd100; d0 = 8'h30; a1 = 12'd200; d1 = 8'h50;
      for (int i = 0; i < 6; i++) begin
         step(0, 0);
         if (g0) begin a0 = a0 + 12'd1; d0 = d0 + 8'd1; end
         if (g1) begin a1 = a1 + 12'd1; d1 = d1 + 8'd1; end
      end
      v0 = 0; v1 = 0;
      step(0, 0);

      // Clear while req1 is pending; req1 served right after the clear
      v1 = 1; a1 = 12'd300; d1 = 8'h77;
      step(0, 1);
      repeat (2400) step(0, 0);
      step(0, 0);
      v1 = 0;
      step(0, 0);

      // Out-of-range request, then good writes with the error held
      v1 = 1; a1 = 12'd2400; d1 = 8'h5A;
      step(0, 0);
      v1 = 0; v0 = 1; a0 = 12'd5; d0 = 8'h01;
      step(0, 0);
      a0 = 12'd2399; d0 = 8'h02;
      step(0, 0);
      v0 = 0;
      step(0, 0);

      // Reset in the middle of a clear (at write 1000)
      step(0, 1);
      repeat (1000) step(0, 0);
      step(1, 0);
      v0 = 1; a0 = 12'd0; d0 = 8'h42;
      step(0, 0);
      v0 = 0;
      step(0, 0);

      // A second clear_start during a clear is ignored
      step(0, 1);
      for (int i = 0; i < 2405; i++) step(0, i == 500);

      // Random traffic respecting the hold-while-not-ready rule
      for (int i = 0; i < 700; i++) begin
         if (!(v0 && !g0)) begin
            v0 = ($urandom_range(0, 3) != 0);
            a0 = rand_addr();
            d0 = 8'($urandom);
         end
         if (!(v1 && !g1)) begin
            v1 = ($urandom_range(0, 3) != 0);
            a1 = rand_addr();
            d1 = 8'($urandom);
         end
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 399) == 0));
      end
      v0 = 0; v1 = 0;
      repeat (2500) step(0, 0);

      @(posedge clock);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
